// File: rtl/vacc_stream.sv
// Lane-wise streaming accumulator: sums packed vector beats per lane (wrapping, no
// inter-lane carry) over a frame and holds the frame sum on a valid/ready output.
module vacc_stream #(
  parameter int LANE_W = 4,
  parameter int DATA_W = 8,
  parameter int BEATS  = 4,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  out_count
);

  localparam int LANES = DATA_W / LANE_W;

  typedef enum logic {ACC, DONE} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] acc;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_inc;
  logic              accept;
  logic              close;

  // Each lane wraps on its own; the carry out of a lane is dropped.
  function automatic logic [DATA_W-1:0] lane_add(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0]        s;
    logic signed [LANE_W-1:0] la;
    logic signed [LANE_W-1:0] lb;
    s = '0;
    for (int i = 0; i < LANES; i++) begin
      la = a[i*LANE_W +: LANE_W];
      lb = b[i*LANE_W +: LANE_W];
      s[i*LANE_W +: LANE_W] = la + lb;
    end
    return s;
  endfunction

  assign accept  = in_valid & in_ready;
  assign cnt_inc = cnt + CNT_W'(1);
  assign close   = accept & (in_last | (cnt_inc == CNT_W'(BEATS)));

  always_ff @(posedge clk) begin
    if (rst) state <= ACC;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ACC: begin
        in_ready = ~rst;
        if (close) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ACC;
      end
      default: state_nxt = ACC;
    endcase
  end

  // Accumulator is cleared on the output handshake so the next frame starts from zero.
  always_ff @(posedge clk) begin
    if (rst || (state == DONE && out_ready)) begin
      acc <= '0;
      cnt <= '0;
    end else if (accept) begin
      acc <= lane_add(acc, in_data);
      cnt <= cnt_inc;
    end
  end

  assign out_data  = out_valid ? acc : '0;
  assign out_count = out_valid ? cnt : '0;

endmodule

// File: tb/tb_vacc_stream.sv
// Directed bench for vacc_stream: a per-cycle vector table plus hand-written
// sequences for reset-in-frame, reset-in-DONE and back-to-back frames.
module tb_vacc_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [2:0] out_count;

  int checks   = 0;
  int failures = 0;

  vacc_stream #(.LANE_W(4), .DATA_W(8), .BEATS(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_count(out_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       l;
    logic       ordy;
    logic       e_ir;
    logic       e_ov;
    logic [7:0] e_od;
    logic [2:0] e_oc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic v, input logic [7:0] d, input logic l, input logic ordy,
                     input logic e_ir, input logic e_ov, input logic [7:0] e_od,
                     input logic [2:0] e_oc);
    vec_t x;
    x.v = v; x.d = d; x.l = l; x.ordy = ordy;
    x.e_ir = e_ir; x.e_ov = e_ov; x.e_od = e_od; x.e_oc = e_oc;
    vecs.push_back(x);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs after the falling edge; outputs settle #1 later.
  task automatic cyc(input logic r, input logic v, input logic [7:0] d, input logic l,
                     input logic ordy);
    @(negedge clk);
    rst = r; in_valid = v; in_data = d; in_last = l; out_ready = ordy;
    #1;
  endtask

  task automatic chk_out(input string name, input logic ir, input logic ov,
                         input logic [7:0] od, input logic [2:0] oc);
    chk({name, ".in_ready"},  int'(in_ready),  int'(ir));
    chk({name, ".out_valid"}, int'(out_valid), int'(ov));
    chk({name, ".out_data"},  int'(out_data),  int'(od));
    chk({name, ".out_count"}, int'(out_count), int'(oc));
  endtask

  int pulses;
  int bubbles;
  int sent;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; out_ready = 1'b0;

    // Test 1: plain 4-beat frame closed by the beat limit
    add(1, 8'h21, 0, 0, 1, 0, 8'h00, 0);
    add(1, 8'h13, 0, 0, 1, 0, 8'h00, 0);
    add(1, 8'h01, 0, 0, 1, 0, 8'h00, 0);
    add(1, 8'h10, 0, 0, 1, 0, 8'h00, 0);
    add(0, 8'h00, 0, 1, 0, 1, 8'h45, 4);
    add(0, 8'h00, 0, 0, 1, 0, 8'h00, 0);
    // Tests 2/3: lane wrap, then DONE held with in_valid asserted
    add(1, 8'hff, 0, 0, 1, 0, 8'h00, 0);
    add(1, 8'h02, 1, 0, 1, 0, 8'h00, 0);
    for (int i = 0; i < 5; i++) add(1, 8'h77, 1, 0, 0, 1, 8'hf1, 2);
    add(1, 8'h77, 1, 1, 0, 1, 8'hf1, 2);
    // in_last on the 4th beat closes exactly one frame; the 77 beats were not taken
    add(1, 8'h11, 0, 0, 1, 0, 8'h00, 0);
    add(1, 8'h11, 0, 0, 1, 0, 8'h00, 0);
    add(1, 8'h11, 0, 0, 1, 0, 8'h00, 0);
    add(1, 8'h11, 1, 0, 1, 0, 8'h00, 0);
    add(0, 8'h00, 0, 1, 0, 1, 8'h44, 4);
    add(0, 8'h00, 0, 0, 1, 0, 8'h00, 0);
    add(0, 8'h00, 0, 0, 1, 0, 8'h00, 0);
    // Test 5: idle gaps with junk data/last inside a frame
    add(1, 8'h21, 0, 0, 1, 0, 8'h00, 0);
    add(0, 8'hff, 1, 0, 1, 0, 8'h00, 0);
    add(1, 8'h13, 0, 0, 1, 0, 8'h00, 0);
    add(0, 8'hee, 1, 0, 1, 0, 8'h00, 0);
    add(0, 8'hee, 1, 0, 1, 0, 8'h00, 0);
    add(1, 8'h01, 0, 0, 1, 0, 8'h00, 0);
    for (int i = 0; i < 3; i++) add(0, 8'hcd, 1, 0, 1, 0, 8'h00, 0);
    add(1, 8'h10, 0, 0, 1, 0, 8'h00, 0);
    add(0, 8'h00, 0, 1, 0, 1, 8'h45, 4);
    add(0, 8'h00, 0, 0, 1, 0, 8'h00, 0);

    // Reset state, with rst still high: in_ready forced low
    cyc(1, 1, 8'h99, 0, 0);
    cyc(1, 1, 8'h99, 0, 0);
    chk_out("reset", 0, 0, 8'h00, 0);

    foreach (vecs[i]) begin
      cyc(0, vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].ordy);
      chk_out($sformatf("vec%0d", i), vecs[i].e_ir, vecs[i].e_ov, vecs[i].e_od, vecs[i].e_oc);
    end

    // Test 4: reset after two beats discards the partial sum
    cyc(0, 1, 8'h11, 0, 1);
    cyc(0, 1, 8'h11, 0, 1);
    cyc(1, 1, 8'h11, 0, 1);
    chk("rst_mid.in_ready", int'(in_ready), 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 8'h11, 0, 0);
      chk("rst_mid.no_out", int'(out_valid), 0);
    end
    cyc(0, 0, 8'h00, 0, 1);
    chk_out("rst_mid.frame", 0, 1, 8'h44, 4);
    cyc(0, 0, 8'h00, 0, 0);

    // Reset while DONE drops the pending sum
    cyc(0, 1, 8'h55, 0, 0);
    cyc(0, 1, 8'h55, 1, 0);
    cyc(0, 0, 8'h00, 0, 0);
    chk_out("rst_done.pending", 0, 1, 8'haa, 2);
    cyc(1, 0, 8'h00, 0, 0);
    cyc(0, 0, 8'h00, 0, 0);
    chk_out("rst_done.after", 1, 0, 8'h00, 0);
    cyc(0, 1, 8'h03, 1, 0);
    cyc(0, 0, 8'h00, 0, 1);
    chk_out("rst_done.next", 0, 1, 8'h03, 1);

    // Test 6: out_ready tied high, three back-to-back 4-beat frames
    pulses = 0; bubbles = 0; sent = 0;
    for (int c = 0; c < 17; c++) begin
      @(negedge clk);
      rst = 1'b0; out_ready = 1'b1; in_last = 1'b0;
      in_valid = (sent < 12);
      in_data  = 8'h11 * 8'((sent / 4) + 1);
      #1;
      if (out_valid) begin
        chk($sformatf("b2b.data%0d", pulses), int'(out_data), 8'h11 * 4 * (pulses + 1));
        chk($sformatf("b2b.count%0d", pulses), int'(out_count), 4);
        pulses++;
      end
      if (!in_ready) bubbles++;
      if (in_valid && in_ready) sent++;
    end
    chk("b2b.pulses", pulses, 3);
    chk("b2b.bubbles", bubbles, 3);
    chk("b2b.sent", sent, 12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
